// File: rtl/mult_share_sched.sv
// Shares one stateless WIDTH x WIDTH multiplier among NUM_REQ requesters: arbitrate, hold operands MULT_LAT cycles, return tagged product.
// Define MULT_SCHED_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module mult_share_sched #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 4,
    parameter int MULT_LAT = 1,
    parameter int ID_W     = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_result,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_data,
    input  logic                     rsp_ready
);

    localparam int CNT_W = $clog2(MULT_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d, id_q, id_d;
    logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    int                   start;
    int                   idx;

`ifdef MULT_SCHED_RR_EN
    logic [ID_W-1:0]      ptr_q, ptr_d;
    assign start = int'(ptr_q);
`else
    assign start = 0;
`endif

    // Scan NUM_REQ slots beginning at 'start', wrapping; first asserted slot wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = start + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rstn && state_q == S_IDLE && win_found) req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
`ifdef MULT_SCHED_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: if (win_found) begin
                mul_a_d = req_a[win_idx*WIDTH +: WIDTH];
                mul_b_d = req_b[win_idx*WIDTH +: WIDTH];
                cnt_d   = CNT_W'(MULT_LAT);
                id_d    = win_idx;
                state_d = S_WAIT;
`ifdef MULT_SCHED_RR_EN
                ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
`endif
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Operands have been stable for MULT_LAT cycles once the count hits 1.
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d  = mul_result;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
`ifdef MULT_SCHED_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
`ifdef MULT_SCHED_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched: one instance with MULT_LAT=1, one with MULT_LAT=3, each fed by a behavioural multiplier.
module tb_mult_share_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic [3:0]  req_valid = '0, req_ready;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_result, rsp_data;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [1:0]  rsp_id;

    logic [3:0]  req_valid3 = '0, req_ready3;
    logic [15:0] req_a3 = '0, req_b3 = '0;
    logic [3:0]  mul_a3, mul_b3;
    logic [7:0]  mul_result3, rsp_data3;
    logic        rsp_valid3, rsp_ready3 = 1'b1;
    logic [1:0]  rsp_id3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mul_result  = mul_a * mul_b;
    assign mul_result3 = mul_a3 * mul_b3;

    mult_share_sched #(.NUM_REQ(4), .WIDTH(4), .MULT_LAT(1), .ID_W(2)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    mult_share_sched #(.NUM_REQ(4), .WIDTH(4), .MULT_LAT(3), .ID_W(2)) dut3 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
        .req_ready(req_ready3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_result(mul_result3),
        .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_data(rsp_data3), .rsp_ready(rsp_ready3)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, mul_a, mul_b, req_ready} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state got v=%0d id=%0d d=%0d a=%0d b=%0d rdy=%b want all 0",
                     rsp_valid, rsp_id, rsp_data, mul_a, mul_b, req_ready);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 0000", req_ready);
        end
        req_valid = '0;
        @(negedge clk) rstn = 1'b1;
        step;
    endtask

    task automatic test_reset_mid_wait;
        req_valid = 4'b0010; req_a = 16'h0050; req_b = 16'h0030;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rmw_grant got %b want 0010", req_ready);
        end
        step;
        checks++;
        if ({mul_a, mul_b} !== {4'd5, 4'd3}) begin
            errors++;
            $display("FAIL rmw_operands got a=%0d b=%0d want a=5 b=3", mul_a, mul_b);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, mul_a, mul_b, req_ready} !== 13'd0) begin
            errors++;
            $display("FAIL rmw_async_clear got v=%0d a=%0d b=%0d rdy=%b want 0", rsp_valid, mul_a, mul_b, req_ready);
        end
        req_valid = '0;
        @(negedge clk) rstn = 1'b1;
        step;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rsp_valid, req_ready} !== 5'd0) begin
                errors++;
                $display("FAIL rmw_no_replay cyc=%0d got v=%0d rdy=%b want 0", i, rsp_valid, req_ready);
            end
            step;
        end
    endtask

    task automatic test_single;
        rsp_ready = 1'b1;
        req_valid = 4'b0001; req_a = 16'h000F; req_b = 16'h000F;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant got %b want 0001", req_ready);
        end
        step;
        req_valid = '0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, mul_a, mul_b} !== {4'b0000, 1'b0, 4'd15, 4'd15}) begin
            errors++;
            $display("FAIL single_wait got rdy=%b v=%0d a=%0d b=%0d want 0000 0 15 15", req_ready, rsp_valid, mul_a, mul_b);
        end
        step;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 8'd225}) begin
            errors++;
            $display("FAIL single_rsp got v=%0d id=%0d d=%0d want 1 0 225", rsp_valid, rsp_id, rsp_data);
        end
        step;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_drop got %0d want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        req_valid = 4'b0100; req_a = 16'h0600; req_b = 16'h0700;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_grant got %b want 0100", req_ready);
        end
        step;
        req_valid = 4'b0001; req_a = 16'h0602; req_b = 16'h0703;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_wait_no_grant got %b want 0000", req_ready);
        end
        step;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 2'd2, 8'd42, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%0d id=%0d d=%0d rdy=%b want 1 2 42 0000",
                         i, rsp_valid, rsp_id, rsp_data, req_ready);
            end
            step;
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_data, req_ready} !== {1'b1, 8'd42, 4'b0000}) begin
            errors++;
            $display("FAIL bp_handshake got v=%0d d=%0d rdy=%b want 1 42 0000", rsp_valid, rsp_data, req_ready);
        end
        step;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL bp_release got v=%0d rdy=%b want 0 0001", rsp_valid, req_ready);
        end
        req_valid = '0;
        #1;
        step;
        checks++;
        if ({req_ready, rsp_valid, mul_a, mul_b} !== {4'b0000, 1'b0, 4'd6, 4'd7}) begin
            errors++;
            $display("FAIL bp_drop_no_xfer got rdy=%b v=%0d a=%0d b=%0d want 0000 0 6 7", req_ready, rsp_valid, mul_a, mul_b);
        end
    endtask

    task automatic test_contention;
        int exp;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        step;
        rsp_ready = 1'b1;
        req_valid = 4'b1111; req_a = 16'h4321; req_b = 16'h2222;
        for (int op = 0; op < 5; op++) begin
`ifdef MULT_SCHED_RR_EN
            exp = op % 4;
`else
            if (op >= 3) req_valid = 4'b1110;
            exp = (op >= 3) ? 1 : 0;
`endif
            #1;
            checks++;
            if (req_ready !== (4'b0001 << exp)) begin
                errors++;
                $display("FAIL cont_grant op=%0d got %b want idx %0d", op, req_ready, exp);
            end
            step;
            step;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(exp), 8'(2 * (exp + 1))}) begin
                errors++;
                $display("FAIL cont_rsp op=%0d got v=%0d id=%0d d=%0d want 1 %0d %0d",
                         op, rsp_valid, rsp_id, rsp_data, exp, 2 * (exp + 1));
            end
            step;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_lat3;
        rsp_ready3 = 1'b1;
        req_valid3 = 4'b1000; req_a3 = 16'h0000; req_b3 = 16'h9000;
        #1;
        checks++;
        if (req_ready3 !== 4'b1000) begin
            errors++;
            $display("FAIL lat3_grant got %b want 1000", req_ready3);
        end
        step;
        req_valid3 = '0;
        for (int w = 0; w < 3; w++) begin
            #1;
            checks++;
            if ({mul_a3, mul_b3, rsp_valid3} !== {4'd0, 4'd9, 1'b0}) begin
                errors++;
                $display("FAIL lat3_wait cyc=%0d got a=%0d b=%0d v=%0d want 0 9 0", w, mul_a3, mul_b3, rsp_valid3);
            end
            step;
        end
        checks++;
        if ({rsp_valid3, rsp_id3, rsp_data3} !== {1'b1, 2'd3, 8'd0}) begin
            errors++;
            $display("FAIL lat3_zero_rsp got v=%0d id=%0d d=%0d want 1 3 0", rsp_valid3, rsp_id3, rsp_data3);
        end
        step;
        req_valid3 = 4'b0010; req_a3 = 16'h0030; req_b3 = 16'h0090;
        #1;
        checks++;
        if (req_ready3 !== 4'b0010) begin
            errors++;
            $display("FAIL lat3_grant2 got %b want 0010", req_ready3);
        end
        step;
        req_valid3 = '0;
        for (int w = 0; w < 3; w++) begin
            #1;
            checks++;
            if ({mul_a3, mul_b3, rsp_valid3} !== {4'd3, 4'd9, 1'b0}) begin
                errors++;
                $display("FAIL lat3_wait2 cyc=%0d got a=%0d b=%0d v=%0d want 3 9 0", w, mul_a3, mul_b3, rsp_valid3);
            end
            step;
        end
        checks++;
        if ({rsp_valid3, rsp_id3, rsp_data3} !== {1'b1, 2'd1, 8'd27}) begin
            errors++;
            $display("FAIL lat3_rsp2 got v=%0d id=%0d d=%0d want 1 1 27", rsp_valid3, rsp_id3, rsp_data3);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_reset_mid_wait;
        test_single;
        test_backpressure;
        test_contention;
        test_lat3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
